// File: rtl/apb_pkg.sv
// apb_pkg: shared APB widths, wait-counter width and completer state encoding
package apb_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int CNT_W      = 4;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;
endpackage

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: DEPTH x DATA_W storage, synchronous write, asynchronous read, async clear
module apb_slave_regfile #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int IW     = 6
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              we_i,
  input  logic [IW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  assign rdata_o = mem_q[raddr_i];
  // storage: whole array cleared on reset, one word written per enabled edge
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) mem_q <= '{default: '0};
    else if (we_i) mem_q[waddr_i] <= wdata_i;
endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer with fixed wait states and out-of-range error response
module apb_slave_mem import apb_pkg::*; #(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] padd,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
  logic              write_q, write_d, err_q, rd_err, we;
  logic [DATA_W-1:0] prdata_q, prdata_d, rdata, rd_val;
  // read address is padd on the setup edge (zero-wait reads) and the latched address afterwards
  assign rd_addr = state_q == IDLE ? padd : addr_q;
  assign rd_err  = int'(rd_addr) >= DEPTH;
  assign rd_val  = rd_err ? '0 : rdata;
  assign err_q   = int'(addr_q) >= DEPTH;
  assign pready  = state_q == ACCESS && cnt_q == '0;
  assign pslverr = pready && err_q;
  assign prdata  = prdata_q;
  apb_slave_regfile #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IW(IW)) u_rf (
    .pclk    (pclk),
    .presetn (presetn),
    .we_i    (we),
    .waddr_i (addr_q[IW-1:0]),
    .wdata_i (pwdata),
    .raddr_i (rd_addr[IW-1:0]),
    .rdata_o (rdata)
  );
  // state, counter, latched request and read data registers
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      prdata_q <= prdata_d;
    end
  // next state: accept setup, count wait states, commit or abort; read data loads as pready rises
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    prdata_d = prdata_q;
    we       = 1'b0;
    if (state_q == IDLE) begin
      if (psel && !penable) begin
        state_d = ACCESS;
        addr_d  = padd;
        write_d = pwrite;
        cnt_d   = CNT_W'(WAIT_CYCLES);
        if (WAIT_CYCLES == 0 && !pwrite) prdata_d = rd_val;
      end
    end else if (!psel) state_d = IDLE;
    else if (penable && pready) begin
      state_d = IDLE;
      we      = write_q && !err_q;
    end else if (penable) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && !write_q) prdata_d = rd_val;
    end
  end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: three completers (0, 1 and 3 wait states) checked against a transfer-level model
module tb_apb_slave_mem;
  logic       clk = 1'b0;
  logic       presetn = 1'b0;
  logic       psel [3];
  logic       penable [3];
  logic       pwrite [3];
  logic [7:0] padd [3];
  logic [7:0] pwdata [3];
  logic [7:0] prdata [3];
  logic       pready [3];
  logic       pslverr [3];
  logic [7:0] mem [3][64];
  logic [7:0] last_rd [3];
  logic       exp_rdy [3];
  logic       exp_err [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_slave_mem #(.WAIT_CYCLES(0)) u_w0 (.pclk(clk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .padd(padd[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));
  apb_slave_mem #(.WAIT_CYCLES(1)) u_w1 (.pclk(clk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .padd(padd[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));
  apb_slave_mem #(.WAIT_CYCLES(3)) u_w3 (.pclk(clk), .presetn(presetn), .psel(psel[2]), .penable(penable[2]),
    .pwrite(pwrite[2]), .padd(padd[2]), .pwdata(pwdata[2]), .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

  function automatic int wc(int k);
    return k == 0 ? 0 : (k == 1 ? 1 : 3);
  endfunction

  task automatic chk(string nm, int k, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d at %0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      last_rd[k] = 8'h00;
      exp_rdy[k] = 1'b0;
      exp_err[k] = 1'b0;
      for (int a = 0; a < 64; a++) mem[k][a] = 8'h00;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int k, int n);
    repeat (n) begin
      step();
      psel[k] = 1'b0;
      penable[k] = 1'b0;
      padd[k] = 8'($urandom);
      pwdata[k] = 8'($urandom);
      exp_rdy[k] = 1'b0;
      exp_err[k] = 1'b0;
    end
  endtask

  task automatic xfer(int k, bit wr, logic [7:0] a, logic [7:0] d, int abort_at);
    int w;
    bit err;
    w = wc(k);
    err = a >= 8'd64;
    step();
    psel[k] = 1'b1;
    penable[k] = 1'b0;
    pwrite[k] = wr;
    padd[k] = a;
    pwdata[k] = 8'($urandom);
    exp_rdy[k] = 1'b0;
    exp_err[k] = 1'b0;
    for (int i = 0; i <= w; i++) begin
      step();
      padd[k] = 8'($urandom);
      if (i == abort_at) begin
        psel[k] = 1'b0;
        penable[k] = 1'b0;
        exp_rdy[k] = 1'b0;
        exp_err[k] = 1'b0;
        return;
      end
      penable[k] = 1'b1;
      pwdata[k] = i == w ? d : 8'($urandom);
      exp_rdy[k] = i == w;
      exp_err[k] = i == w && err;
      if (i == w && wr && !err) mem[k][a[5:0]] = d;
      if (i == w && !wr) last_rd[k] = err ? 8'h00 : mem[k][a[5:0]];
    end
  endtask

  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      chk("pready", k, 8'(pready[k]), 8'(exp_rdy[k]));
      chk("pslverr", k, 8'(pslverr[k]), 8'(exp_err[k]));
      chk("prdata", k, prdata[k], last_rd[k]);
    end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      psel[k] = 1'b0;
      penable[k] = 1'b0;
      pwrite[k] = 1'b0;
      padd[k] = 8'h00;
      pwdata[k] = 8'h00;
    end
    model_reset();
    repeat (3) step();
    @(negedge clk);
    chk("rst_prdata", 1, prdata[1], 8'h00);
    chk("rst_pready", 1, 8'(pready[1]), 8'h00);
    chk("rst_pslverr", 1, 8'(pslverr[1]), 8'h00);
    step();
    presetn = 1'b1;
    xfer(1, 1'b0, 8'h05, 8'h00, -1);
    @(negedge clk);
    chk("rd05", 1, prdata[1], 8'h00);
    idle(1, 1);
    xfer(1, 1'b1, 8'h10, 8'hA5, -1);
    @(negedge clk);
    chk("wr10_ready", 1, 8'(pready[1]), 8'h01);
    xfer(1, 1'b0, 8'h10, 8'h00, -1);
    @(negedge clk);
    chk("rd10", 1, prdata[1], 8'hA5);
    chk("rd10_err", 1, 8'(pslverr[1]), 8'h00);
    idle(1, 1);
    xfer(0, 1'b1, 8'h00, 8'h01, -1);
    xfer(0, 1'b1, 8'h01, 8'h02, -1);
    xfer(0, 1'b0, 8'h00, 8'h00, -1);
    @(negedge clk);
    chk("b2b_rd0", 0, prdata[0], 8'h01);
    xfer(0, 1'b0, 8'h01, 8'h00, -1);
    @(negedge clk);
    chk("b2b_rd1", 0, prdata[0], 8'h02);
    idle(0, 1);
    xfer(1, 1'b1, 8'h40, 8'hFF, -1);
    @(negedge clk);
    chk("oor_wr_err", 1, 8'(pslverr[1]), 8'h01);
    xfer(1, 1'b0, 8'h40, 8'h00, -1);
    @(negedge clk);
    chk("oor_rd", 1, prdata[1], 8'h00);
    chk("oor_rd_err", 1, 8'(pslverr[1]), 8'h01);
    xfer(1, 1'b0, 8'h00, 8'h00, -1);
    @(negedge clk);
    chk("oor_alias", 1, prdata[1], 8'h00);
    idle(1, 1);
    xfer(2, 1'b1, 8'h02, 8'h11, -1);
    xfer(2, 1'b1, 8'h02, 8'h33, 1);
    repeat (2) begin
      step();
      psel[2] = 1'b1;
      penable[2] = 1'b1;
    end
    @(negedge clk);
    chk("no_setup", 2, 8'(pready[2]), 8'h00);
    xfer(2, 1'b0, 8'h02, 8'h00, -1);
    @(negedge clk);
    chk("abort_rd", 2, prdata[2], 8'h11);
    xfer(2, 1'b1, 8'h03, 8'h77, 2);
    step();
    psel[2] = 1'b1;
    penable[2] = 1'b1;
    #2;
    presetn = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_ready", 2, 8'(pready[2]), 8'h00);
    chk("rst_mid_prdata", 0, prdata[0], 8'h00);
    idle(2, 1);
    presetn = 1'b1;
    xfer(2, 1'b0, 8'h03, 8'h00, -1);
    @(negedge clk);
    chk("rst_rd03", 2, prdata[2], 8'h00);
    xfer(2, 1'b0, 8'h02, 8'h00, -1);
    @(negedge clk);
    chk("rst_rd02", 2, prdata[2], 8'h00);
    idle(2, 1);
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 80; n++) begin
        logic [7:0] a;
        int ab;
        int gap;
        a = ($urandom % 5 == 0) ? 8'($urandom_range(64, 79)) : 8'($urandom_range(0, 7));
        ab = (wc(k) > 0 && $urandom % 6 == 0) ? int'($urandom_range(0, wc(k) - 1)) : -1;
        xfer(k, 1'($urandom), a, 8'($urandom), ab);
        gap = int'($urandom % 3);
        if (gap > 0) idle(k, gap);
      end
      idle(k, 1);
    end
    idle(0, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
